// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Moore control FSM for a multi-cycle datapath with a shared instruction/data
// memory, IR, MDR, ALUOut and PC. It sequences R-type, ADDI/ANDI/ORI, LW/SW,
// BEQ/BNE/BGT/BGE/BLT/BLE and J/JAL. It waits on the memory ready handshake
// and parks in TRAP on an illegal opcode until reset.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   opcode         IR[31:26], sampled only in DECODE
//   mem_ready      memory completes the current read/write this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if the branch_type condition holds
//   branch_type    0=EQ 1=NE 2=GT 3=GE 4=LT 5=LE
//   pc_source      0=ALU result 1=ALUOut 2=jump target
//   ir_write       IR load
//   iord           memory address select: 0=PC 1=ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   mem_to_reg     writeback data: 0=ALUOut 1=MDR 2=PC (link)
//   reg_dst        writeback register: 0=rt 1=rd 2=$31
//   reg_write      register file write
//   alu_src_a      ALU A: 0=PC 1=rs
//   alu_src_b      ALU B: 0=rt 1=4 2=sext imm 3=sext imm<<2
//   ALUOp          0=ADD 1=SUB 2=AND 3=OR F=use funct
//   instr_done     one-cycle pulse in the final state of each instruction
//   illegal_op     high while parked in TRAP
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic [2:0]          branch_type,
   output logic [1:0]          pc_source,
   output logic                ir_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic [1:0]          mem_to_reg,
   output logic [1:0]          reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic                instr_done,
   output logic                illegal_op
);

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
   localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
   localparam logic [OPCODE_W-1:0] OP_BGT  = OPCODE_W'(6'b001110);
   localparam logic [OPCODE_W-1:0] OP_BGE  = OPCODE_W'(6'b010001);
   localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(6'b010010);
   localparam logic [OPCODE_W-1:0] OP_BLE  = OPCODE_W'(6'b010011);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(4'h0);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(4'h1);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(4'h2);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4'h3);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(4'hF);

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [OPCODE_W-1:0] r_op_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_RST;
         r_op_q  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_op_q <= opcode;
      end
   end

   always_comb begin
      // NOTE: every output and w_next gets a default first, so no path through
      // the case statement can leave a signal unassigned and infer a latch.
      w_next        = S_RST;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_type   = 3'd0;
      pc_source     = 2'd0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 2'd0;
      reg_dst       = 2'd0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      ALUOp         = ALU_ADD;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;

      case (r_state)
         S_RST: w_next = S_FETCH;

         S_FETCH: begin
            // PC+4 is computed every cycle, but IR and PC only load on the
            // cycle the memory actually delivers the instruction.
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            w_next    = mem_ready ? S_DECODE : S_FETCH;
         end

         S_DECODE: begin
            // Branch target (PC + imm<<2) is precomputed into ALUOut here.
            alu_src_b = 2'd3;
            case (opcode)
               OP_R:                             w_next = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI:         w_next = S_EXEC_I;
               OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BGT,
               OP_BGE, OP_BLT, OP_BLE:           w_next = S_BRANCH;
               OP_J, OP_JAL:                     w_next = S_JUMP;
               default:                          w_next = S_TRAP;
            endcase
         end

         S_EXEC_R: begin
            alu_src_a = 1'b1;
            ALUOp     = ALU_FUNCT;
            w_next    = S_ALU_WB;
         end

         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            case (r_op_q)
               OP_ANDI: ALUOp = ALU_AND;
               OP_ORI:  ALUOp = ALU_OR;
               default: ALUOp = ALU_ADD;
            endcase
            w_next = S_ALU_WB;
         end

         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (r_op_q == OP_R) ? 2'd1 : 2'd0;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end

         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            w_next    = (r_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            w_next   = mem_ready ? S_MEM_WB : S_MEM_RD;
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'd1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end

         S_MEM_WR: begin
            // A store retires on the cycle the memory accepts it.
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
            w_next     = mem_ready ? S_FETCH : S_MEM_WR;
         end

         S_BRANCH: begin
            alu_src_a     = 1'b1;
            ALUOp         = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
            case (r_op_q)
               OP_BNE:  branch_type = 3'd1;
               OP_BGT:  branch_type = 3'd2;
               OP_BGE:  branch_type = 3'd3;
               OP_BLT:  branch_type = 3'd4;
               OP_BLE:  branch_type = 3'd5;
               default: branch_type = 3'd0;
            endcase
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end

         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            instr_done = 1'b1;
            // PC already holds PC+4 from FETCH, which is the link value.
            if (r_op_q == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
            end
            w_next = S_FETCH;
         end

         S_TRAP: begin
            illegal_op = 1'b1;
            w_next     = S_TRAP;
         end

         default: w_next = S_RST;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Self-checking bench for multicycle_control_fsm. A reference model describes
// each instruction class as a numbered list of steps (step 0 = fetch, step 1 =
// decode) and derives the expected outputs of every cycle from the class, the
// step number and mem_ready. Directed sequences pin the model with literal
// latencies and output values; a long randomized run covers the rest.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
   logic       reg_write, alu_src_a, instr_done, illegal_op;
   logic [2:0] branch_type;
   logic [1:0] pc_source, mem_to_reg, reg_dst, alu_src_b;
   logic [3:0] ALUOp;

   multicycle_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .branch_type(branch_type), .pc_source(pc_source), .ir_write(ir_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
      .instr_done(instr_done), .illegal_op(illegal_op)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [2:0] branch_type;
      logic [1:0] pc_source;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } outs_t;

   outs_t act;
   assign act = {pc_write, pc_write_cond, branch_type, pc_source, ir_write,
                 iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                 alu_src_a, alu_src_b, ALUOp, instr_done, illegal_op};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {C_R, C_I, C_LW, C_SW, C_BR, C_J, C_BAD} cls_t;

   function automatic cls_t classify(input logic [5:0] op);
      case (op)
         6'd0:                                  return C_R;
         6'd8, 6'd12, 6'd13:                    return C_I;
         6'd35:                                 return C_LW;
         6'd43:                                 return C_SW;
         6'd4, 6'd5, 6'd14, 6'd17, 6'd18, 6'd19: return C_BR;
         6'd2, 6'd3:                            return C_J;
         default:                               return C_BAD;
      endcase
   endfunction

   // Number of steps (cycles with no stalls) in each class.
   function automatic int seq_len(input cls_t c);
      case (c)
         C_R, C_I, C_SW: return 4;
         C_LW:           return 5;
         default:        return 3;
      endcase
   endfunction

   function automatic outs_t expect_outs(input bit in_rst, input cls_t c,
                                         input int k, input logic [5:0] op,
                                         input logic rdy);
      outs_t e = '0;
      if (in_rst) return e;
      if (k == 0) begin
         e.mem_read = 1; e.alu_src_b = 1; e.ir_write = rdy; e.pc_write = rdy;
         return e;
      end
      if (k == 1) begin
         e.alu_src_b = 3;
         return e;
      end
      case (c)
         C_R, C_I: begin
            if (k == 2) begin
               e.alu_src_a = 1;
               if (c == C_R) e.alu_op = 4'hF;
               else begin
                  e.alu_src_b = 2;
                  e.alu_op = (op == 6'd12) ? 4'd2 : (op == 6'd13) ? 4'd3 : 4'd0;
               end
            end else begin
               e.reg_write = 1; e.instr_done = 1;
               e.reg_dst = (c == C_R) ? 2'd1 : 2'd0;
            end
         end
         C_LW, C_SW: begin
            if (k == 2) begin
               e.alu_src_a = 1; e.alu_src_b = 2;
            end else if (k == 3) begin
               e.iord = 1;
               if (c == C_LW) e.mem_read = 1;
               else begin
                  e.mem_write = 1; e.instr_done = rdy;
               end
            end else begin
               e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
            end
         end
         C_BR: begin
            e.alu_src_a = 1; e.alu_op = 1; e.pc_write_cond = 1; e.pc_source = 1;
            e.instr_done = 1;
            case (op)
               6'd5:    e.branch_type = 1;
               6'd14:   e.branch_type = 2;
               6'd17:   e.branch_type = 3;
               6'd18:   e.branch_type = 4;
               6'd19:   e.branch_type = 5;
               default: e.branch_type = 0;
            endcase
         end
         C_J: begin
            e.pc_write = 1; e.pc_source = 2; e.instr_done = 1;
            if (op == 6'd3) begin
               e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 2;
            end
         end
         default: e.illegal_op = 1;
      endcase
      return e;
   endfunction

   bit         m_valid = 0;
   bit         m_rst   = 1;
   cls_t       m_cls   = C_R;
   int         m_k     = 0;
   logic [5:0] m_op    = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1; m_rst <= 1; m_k <= 0;
      end else if (m_rst) begin
         m_rst <= 0; m_k <= 0;
      end else if (m_k == 1) begin
         m_cls <= classify(opcode); m_op <= opcode; m_k <= 2;
      end else if (m_k == 0 || (m_k == 3 && (m_cls == C_LW || m_cls == C_SW))) begin
         // Memory-wait steps advance only when the memory completes.
         if (mem_ready) m_k <= (m_k == seq_len(m_cls) - 1) ? 0 : m_k + 1;
      end else if (m_cls != C_BAD) begin
         m_k <= (m_k == seq_len(m_cls) - 1) ? 0 : m_k + 1;
      end
   end

   // Compare process: every cycle, away from the rising edge.
   always @(negedge clk) begin
      #2;
      if (m_valid)
         check("outputs", 32'(act), 32'(expect_outs(m_rst, m_cls, m_k, m_op, mem_ready)));
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic rdy, input logic [5:0] op, input logic rst);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      rst_n     = rst;
      #3;
   endtask

   // Runs one instruction from FETCH entry; bit c of rdy_mask is mem_ready in
   // cycle c. Returns the cycle count up to instr_done (0 on timeout).
   task automatic run_instr(input logic [5:0] op, input logic [31:0] rdy_mask,
                            output int n, output outs_t first_o, output outs_t done_o);
      n = 0;
      first_o = '0;
      done_o = '0;
      for (int c = 0; c < 32; c++) begin
         cyc(rdy_mask[c], op, 1'b1);
         if (c == 0) first_o = act;
         if (instr_done) begin
            n = c + 1;
            done_o = act;
            break;
         end
      end
      if (n == 0) begin
         n_errors++;
         n_checks++;
         $display("FAIL timeout waiting for instr_done, opcode %b", op);
      end
   endtask

   localparam logic [5:0] BR_OPS [6] = '{6'd4, 6'd5, 6'd14, 6'd17, 6'd18, 6'd19};
   localparam logic [5:0] LEGAL [16] = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43,
                                         6'd4, 6'd5, 6'd14, 6'd17, 6'd18, 6'd19,
                                         6'd2, 6'd3, 6'd0, 6'd35};

   initial begin
      int    n;
      outs_t f, d;
      logic [5:0] op;

      rst_n = 1'b0; mem_ready = 1'b1; opcode = '0;

      // 1. Reset: two cycles low, then one cycle in RST with all outputs 0.
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 1);
      check("rst_all_zero", 32'(act), 32'd0);

      // 2. R-type: 4 cycles, first cycle is FETCH.
      run_instr(6'd0, '1, n, f, d);
      check("fetch_mem_read", 32'(f.mem_read), 32'd1);
      check("fetch_iord", 32'(f.iord), 32'd0);
      check("fetch_alu_src_b", 32'(f.alu_src_b), 32'd1);
      check("r_cycles", n, 4);
      check("r_reg_dst", 32'(d.reg_dst), 32'd1);
      check("r_reg_write", 32'(d.reg_write), 32'd1);

      // ORI: 4 cycles, reg_dst=rt.
      run_instr(6'd13, '1, n, f, d);
      check("ori_cycles", n, 4);
      check("ori_reg_dst", 32'(d.reg_dst), 32'd0);

      // 3. LW with 3 stall cycles in MEM_RD (cycles 3..5): 8 cycles.
      run_instr(6'd35, ~32'h38, n, f, d);
      check("lw_cycles", n, 8);
      check("lw_mem_to_reg", 32'(d.mem_to_reg), 32'd1);

      // Fetch stall of 2 cycles on SW: 4 + 2.
      run_instr(6'd43, ~32'h3, n, f, d);
      check("sw_cycles", n, 6);

      // 4. Branch sweep: 3 cycles, branch_type 0..5.
      for (int i = 0; i < 6; i++) begin
         run_instr(BR_OPS[i], '1, n, f, d);
         check("br_cycles", n, 3);
         check("br_pc_write_cond", 32'(d.pc_write_cond), 32'd1);
         check("br_type", 32'(d.branch_type), i);
      end

      // 5. JAL then J.
      run_instr(6'd3, '1, n, f, d);
      check("jal_cycles", n, 3);
      check("jal_pc_source", 32'(d.pc_source), 32'd2);
      check("jal_link", 32'({d.reg_write, d.reg_dst, d.mem_to_reg}), 32'b1_10_10);
      run_instr(6'd2, '1, n, f, d);
      check("j_reg_write", 32'(d.reg_write), 32'd0);
      check("j_pc_write", 32'(d.pc_write), 32'd1);

      // 6. Illegal opcode: absorbing TRAP regardless of inputs.
      cyc(1, 6'h3f, 1);
      cyc(1, 6'h3f, 1);
      for (int i = 0; i < 20; i++) begin
         cyc(1'($urandom_range(0, 1)), 6'($urandom), 1'b1);
         check("trap_illegal_op", 32'(illegal_op), 32'd1);
      end
      cyc(1, 0, 0);
      cyc(1, 0, 1);
      check("trap_reset_exit", 32'(illegal_op), 32'd0);

      // Reset during MEM_WR with mem_ready low: store never completes.
      cyc(1, 6'd43, 1);
      cyc(1, 6'd43, 1);
      cyc(1, 6'd43, 1);
      cyc(0, 6'd43, 0);
      check("memwr_mem_write", 32'(mem_write), 32'd1);
      check("memwr_no_done", 32'(instr_done), 32'd0);
      cyc(0, 6'd43, 1);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_no_done", 32'(instr_done), 32'd0);

      // Randomized run, checked every cycle by the compare process.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) op = 6'($urandom);
         else op = LEGAL[$urandom_range(0, 15)];
         cyc(1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 299) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
